uart_cmd_deframer: RTL and testbench

//  Downstream consumer of the UART interface: drains received bytes, decodes register read/write frames
//  and drives a simple req/ack register bus. Serialises read data back into the UART TX path.

---
 rtl/uart_cmd_deframer.sv | 213 +++++++++++++++++++++
 tb/tb_uart_cmd_deframer.sv | 524 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_deframer.sv
// uart_cmd_deframer: drains UART RX bytes, decodes register read/write
// frames, drives a req/ack register bus and serialises read data to UART TX.
// Frame: header {write, addr[6:0]}; writes add DATA_BYTES bytes, LSB first.
// Read responses go out as DATA_BYTES bytes, LSB first.
// Optional feature macro: UART_CMD_DEFRAMER_CHECKSUM_EN
//   request frames end with an XOR byte over all earlier frame bytes;
//   read responses append the XOR of the data bytes.
// Ports:
//   CLK_I, RST_I               clock, synchronous active-high reset
//   RX_EMPTY_I, RE_O, DREC_I   RX FIFO drain; byte taken when RE_O=1
//   TX_READY_I, WE_O, DSEND_O  TX byte strobe and data
//   REQ_O, WE_REG_O, ADDR_O    register bus request, direction, address
//   WDATA_O, ACK_I, RDATA_I    register bus write data, ack, read data
//   BUSY_O                     frame or request in progress
//   ERR_O                      one-cycle pulse on frame abort
module uart_cmd_deframer #(
    parameter int DATA_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic                    RX_EMPTY_I,
    output logic                    RE_O,
    input  logic [7:0]              DREC_I,
    input  logic                    TX_READY_I,
    output logic                    WE_O,
    output logic [7:0]              DSEND_O,
    output logic                    REQ_O,
    output logic                    WE_REG_O,
    output logic [6:0]              ADDR_O,
    output logic [8*DATA_BYTES-1:0] WDATA_O,
    input  logic                    ACK_I,
    input  logic [8*DATA_BYTES-1:0] RDATA_I,
    output logic                    BUSY_O,
    output logic                    ERR_O
);
    localparam int W = 8 * DATA_BYTES;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RX_DATA = 3'd1;
    localparam logic [2:0] ST_REQ     = 3'd3;
    localparam logic [2:0] ST_TX_DATA = 3'd4;
`ifdef UART_CMD_DEFRAMER_CHECKSUM_EN
    localparam logic [2:0] ST_RX_CSUM = 3'd2;
    localparam logic [2:0] ST_TX_CSUM = 3'd5;
    localparam logic [2:0] ST_RX_END  = ST_RX_CSUM;
    localparam logic [2:0] ST_TX_END  = ST_TX_CSUM;
`else
    localparam logic [2:0] ST_RX_END  = ST_REQ;
    localparam logic [2:0] ST_TX_END  = ST_IDLE;
`endif

    localparam logic [2:0]  LAST    = 3'(DATA_BYTES - 1);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state;
    logic [2:0]  cnt;
    logic [31:0] tcnt;
    logic        hold;
    logic        err_q;
    logic        we_reg_q;
    logic [6:0]  addr_q;
    logic [W-1:0] wdata_q;
    logic [W-1:0] rdata_q;
    logic        rx_wait;
    logic        tx_state;
    logic        to_hit;
    logic        rd;
    logic        tx_fire;
    logic [7:0]  tx_byte;
`ifdef UART_CMD_DEFRAMER_CHECKSUM_EN
    logic [7:0]  csum_q;
    logic [7:0]  tx_csum;
`endif

`ifdef UART_CMD_DEFRAMER_CHECKSUM_EN
    assign rx_wait  = (state == ST_RX_DATA) || (state == ST_RX_CSUM);
    assign tx_state = (state == ST_TX_DATA) || (state == ST_TX_CSUM);
`else
    assign rx_wait  = (state == ST_RX_DATA);
    assign tx_state = (state == ST_TX_DATA);
`endif

    // The timeout cycle itself never consumes a byte; it becomes the next header.
    assign to_hit  = rx_wait && (tcnt == TO_LAST);
    assign rd      = !RST_I && !RX_EMPTY_I && !to_hit
                   && ((state == ST_IDLE) || rx_wait);
    // hold masks the cycle after a strobe, while UART ready still lags.
    assign tx_fire = !RST_I && tx_state && TX_READY_I && !hold;

`ifdef UART_CMD_DEFRAMER_CHECKSUM_EN
    always_comb begin
        tx_csum = 8'h00;
        for (int i = 0; i < DATA_BYTES; i++)
            tx_csum = tx_csum ^ rdata_q[8*i +: 8];
    end
`endif

    always_comb begin
        tx_byte = 8'h00;
        for (int i = 0; i < DATA_BYTES; i++)
            if (cnt == 3'(i)) tx_byte = rdata_q[8*i +: 8];
`ifdef UART_CMD_DEFRAMER_CHECKSUM_EN
        if (state == ST_TX_CSUM) tx_byte = tx_csum;
`endif
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            tcnt     <= '0;
            hold     <= 1'b0;
            err_q    <= 1'b0;
            we_reg_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
`ifdef UART_CMD_DEFRAMER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            hold  <= tx_fire;
            tcnt  <= (!rx_wait || rd || to_hit) ? '0 : tcnt + 32'd1;
            unique case (state)
                ST_IDLE: begin
                    cnt     <= '0;
                    wdata_q <= '0;
                    if (rd) begin
                        we_reg_q <= DREC_I[7];
                        addr_q   <= DREC_I[6:0];
`ifdef UART_CMD_DEFRAMER_CHECKSUM_EN
                        csum_q   <= DREC_I;
`endif
                        state <= DREC_I[7] ? ST_RX_DATA : ST_RX_END;
                    end
                end
                ST_RX_DATA: begin
                    if (to_hit) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else if (rd) begin
                        for (int i = 0; i < DATA_BYTES; i++)
                            if (cnt == 3'(i)) wdata_q[8*i +: 8] <= DREC_I;
`ifdef UART_CMD_DEFRAMER_CHECKSUM_EN
                        csum_q <= csum_q ^ DREC_I;
`endif
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= ST_RX_END;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_CMD_DEFRAMER_CHECKSUM_EN
                ST_RX_CSUM: begin
                    if (to_hit) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else if (rd) begin
                        if (DREC_I == csum_q) begin
                            state <= ST_REQ;
                        end else begin
                            err_q <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end
`endif
                ST_REQ: begin
                    if (ACK_I) begin
                        if (we_reg_q) begin
                            state <= ST_IDLE;
                        end else begin
                            rdata_q <= RDATA_I;
                            cnt     <= '0;
                            state   <= ST_TX_DATA;
                        end
                    end
                end
                ST_TX_DATA: begin
                    if (tx_fire) begin
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= ST_TX_END;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_CMD_DEFRAMER_CHECKSUM_EN
                ST_TX_CSUM: begin
                    if (tx_fire) state <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign RE_O     = rd;
    assign WE_O     = tx_fire;
    assign DSEND_O  = tx_fire ? tx_byte : 8'h00;
    assign REQ_O    = (state == ST_REQ);
    assign WE_REG_O = we_reg_q;
    assign ADDR_O   = addr_q;
    assign WDATA_O  = wdata_q;
    assign BUSY_O   = (state != ST_IDLE);
    assign ERR_O    = err_q;

endmodule

// File: tb/tb_uart_cmd_deframer.sv
// tb_uart_cmd_deframer: directed bench for uart_cmd_deframer
// (DATA_BYTES=4, TIMEOUT_CYCLES=64).
module tb_uart_cmd_deframer;
    localparam int DB = 4;
    localparam int TO = 64;
`ifdef UART_CMD_DEFRAMER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_empty = 1'b1;
    logic [7:0]  drec = 8'h00;
    logic        tx_ready = 1'b1;
    logic        ack = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        re;
    logic        we;
    logic [7:0]  dsend;
    logic        req;
    logic        we_reg;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic        err;

    uart_cmd_deframer #(
        .DATA_BYTES(DB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK_I(clk),
        .RST_I(rst),
        .RX_EMPTY_I(rx_empty),
        .RE_O(re),
        .DREC_I(drec),
        .TX_READY_I(tx_ready),
        .WE_O(we),
        .DSEND_O(dsend),
        .REQ_O(req),
        .WE_REG_O(we_reg),
        .ADDR_O(addr),
        .WDATA_O(wdata),
        .ACK_I(ack),
        .RDATA_I(rdata),
        .BUSY_O(busy),
        .ERR_O(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rx_q[$];
    logic [7:0] fr_x = 8'h00;
    logic [7:0] tx_b[$];
    int         tx_c[$];
    int         req_c[$];
    int         err_cnt = 0;
    int         err_cyc = -1;
    int         ack_cyc = -1;
    int         last_re = -1;
    int         re_cnt = 0;
    logic       re_n = 1'b0;
    logic       req_d = 1'b0;

    always @(negedge clk) begin
        re_n = re;
        if (re === 1'b1) begin
            last_re = cyc;
            re_cnt++;
        end
        if (we === 1'b1) begin
            tx_b.push_back(dsend);
            tx_c.push_back(cyc);
        end
        if (err === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (req === 1'b1 && req_d !== 1'b1) req_c.push_back(cyc);
        if (req === 1'b1 && ack === 1'b1) ack_cyc = cyc;
        req_d = req;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic refresh();
        rx_empty = (rx_q.size() == 0);
        drec = rx_empty ? 8'h00 : rx_q[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (re_n && rx_q.size() > 0) void'(rx_q.pop_front());
        refresh();
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic step();
        tick();
        mid();
    endtask

    task automatic push(input logic [7:0] b);
        rx_q.push_back(b);
        fr_x = fr_x ^ b;
        refresh();
    endtask

    task automatic end_frame();
        logic [7:0] x;
        x = fr_x;
        if (CS != 0) push(x);
        fr_x = 8'h00;
    endtask

    task automatic wait_req(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_tx(input int n, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (tx_b.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_ack(input logic [31:0] d);
        tick();
        rdata = d;
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        mid();
        checks++;
        if ({re, we, req, we_reg, busy, err, dsend, addr, wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outs got %b exp 0",
                     {re, we, req, we_reg, busy, err, dsend, addr, wdata});
        end
        tick();
        rst = 1'b0;
        mid();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b exp 0", busy);
        end
    endtask

    task automatic test_write();
        logic ok;
        int c;
        int r0;
        int t0;
        int e0;
        r0 = req_c.size();
        t0 = tx_b.size();
        e0 = err_cnt;
        tick();
        c = cyc;
        push(8'h85); push(8'h78); push(8'h56); push(8'h34); push(8'h12);
        end_frame();
        wait_req(ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL wr_req_seen got %b exp 1", ok);
        end
        if (ok) begin
            checks++;
            if (req_c[r0] !== c + 5 + CS) begin
                errors++;
                $display("FAIL wr_req_cycle got %0d exp %0d",
                         req_c[r0], c + 5 + CS);
            end
            checks++;
            if (req_c[r0] !== last_re + 1) begin
                errors++;
                $display("FAIL wr_latency got %0d exp %0d",
                         req_c[r0], last_re + 1);
            end
            checks++;
            if ({we_reg, addr, wdata} !== {1'b1, 7'h05, 32'h12345678}) begin
                errors++;
                $display("FAIL wr_fields got %b %h %h exp 1 05 12345678",
                         we_reg, addr, wdata);
            end
            step();
            step();
            checks++;
            if (req !== 1'b1 || wdata !== 32'h12345678) begin
                errors++;
                $display("FAIL wr_req_held got %b %h exp 1 12345678",
                         req, wdata);
            end
            do_ack(32'hDEADBEEF);
            mid();
            checks++;
            if ({req, busy} !== 2'b00) begin
                errors++;
                $display("FAIL wr_after_ack got %b exp 00", {req, busy});
            end
        end
        repeat (10) step();
        checks++;
        if (tx_b.size() !== t0 || err_cnt !== e0 || req_c.size() !== r0 + 1) begin
            errors++;
            $display("FAIL wr_side tx %0d err %0d req %0d exp %0d %0d %0d",
                     tx_b.size(), err_cnt, req_c.size(), t0, e0, r0 + 1);
        end
    endtask

    task automatic test_read_stall();
        logic ok;
        int t0;
        int s;
        logic [7:0] exp [5] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hC9};
        t0 = tx_b.size();
        tick();
        push(8'h10);
        end_frame();
        wait_req(ok);
        checks++;
        if (ok !== 1'b1 || {we_reg, addr} !== {1'b0, 7'h10}) begin
            errors++;
            $display("FAIL rd_req got %b %b %h exp 1 0 10", ok, we_reg, addr);
        end
        do_ack(32'hCAFEF00D);
        wait_tx(t0 + 2, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL rd_first_bytes got %0d exp %0d", tx_b.size(), t0 + 2);
        end
        tick();
        tx_ready = 1'b0;
        s = cyc;
        mid();
        repeat (19) step();
        checks++;
        if (tx_b.size() !== t0 + 2) begin
            errors++;
            $display("FAIL rd_stall got %0d exp %0d", tx_b.size(), t0 + 2);
        end
        tick();
        tx_ready = 1'b1;
        wait_tx(t0 + DB + CS, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL rd_all_bytes got %0d exp %0d",
                     tx_b.size(), t0 + DB + CS);
        end
        if (ok) begin
            for (int i = 0; i < DB + CS; i++) begin
                checks++;
                if (tx_b[t0+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL rd_byte%0d got %h exp %h", i, tx_b[t0+i], exp[i]);
                end
            end
            for (int i = 1; i < DB + CS; i++) begin
                checks++;
                if (tx_c[t0+i] - tx_c[t0+i-1] < 2) begin
                    errors++;
                    $display("FAIL rd_gap%0d got %0d exp >=2", i,
                             tx_c[t0+i] - tx_c[t0+i-1]);
                end
            end
            checks++;
            if (tx_c[t0] < ack_cyc + 1) begin
                errors++;
                $display("FAIL rd_ack_lat got %0d exp >=%0d", tx_c[t0], ack_cyc + 1);
            end
            checks++;
            if (tx_c[t0+2] < s + 20) begin
                errors++;
                $display("FAIL rd_stall_resume got %0d exp >=%0d", tx_c[t0+2], s + 20);
            end
        end
        repeat (4) step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_idle got %b exp 0", busy);
        end
    endtask

    task automatic test_timeout();
        logic ok;
        int c;
        int r0;
        int t0;
        int e0;
        r0 = req_c.size();
        t0 = tx_b.size();
        e0 = err_cnt;
        tick();
        c = cyc;
        push(8'h81);
        push(8'hAA);
        fr_x = 8'h00;
        repeat (65) tick();
        push(8'h02);
        end_frame();
        mid();
        checks++;
        if ({re, err, busy, rx_empty} !== 4'b0010) begin
            errors++;
            $display("FAIL to_edge got %b exp 0010", {re, err, busy, rx_empty});
        end
        step();
        checks++;
        if (err !== 1'b1 || err_cyc !== c + 66) begin
            errors++;
            $display("FAIL to_err got %b at %0d exp 1 at %0d", err, err_cyc, c + 66);
        end
        wait_req(ok);
        checks++;
        if (ok !== 1'b1 || {we_reg, addr} !== {1'b0, 7'h02}) begin
            errors++;
            $display("FAIL to_next_hdr got %b %b %h exp 1 0 02", ok, we_reg, addr);
        end
        checks++;
        if (err_cnt !== e0 + 1 || req_c.size() !== r0 + 1) begin
            errors++;
            $display("FAIL to_counts err %0d req %0d exp %0d %0d",
                     err_cnt, req_c.size(), e0 + 1, r0 + 1);
        end
        do_ack(32'h0);
        wait_tx(t0 + DB + CS, ok);
        repeat (4) step();
    endtask

    task automatic test_reset_mid_req();
        logic ok;
        int r0;
        int t0;
        int e0;
        r0 = req_c.size();
        t0 = tx_b.size();
        e0 = err_cnt;
        tick();
        push(8'h11);
        end_frame();
        wait_req(ok);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mid();
        checks++;
        if ({ok, req, busy} !== 3'b100) begin
            errors++;
            $display("FAIL rst_req got %b exp 100", {ok, req, busy});
        end
        tick();
        rdata = 32'h55AA55AA;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (10) step();
        checks++;
        if (tx_b.size() !== t0 || busy !== 1'b0 || err_cnt !== e0
            || req_c.size() !== r0 + 1) begin
            errors++;
            $display("FAIL rst_late_ack tx %0d busy %b err %0d req %0d",
                     tx_b.size(), busy, err_cnt, req_c.size());
        end
    endtask

`ifdef UART_CMD_DEFRAMER_CHECKSUM_EN
    task automatic test_checksum();
        logic ok;
        int r0;
        int t0;
        int e0;
        logic [7:0] exp [5] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
        tick();
        push(8'h03);
        push(8'h03);
        fr_x = 8'h00;
        wait_req(ok);
        checks++;
        if (ok !== 1'b1 || {we_reg, addr} !== {1'b0, 7'h03}) begin
            errors++;
            $display("FAIL cs_req got %b %b %h exp 1 0 03", ok, we_reg, addr);
        end
        t0 = tx_b.size();
        do_ack(32'h11223344);
        wait_tx(t0 + 5, ok);
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (tx_b[t0+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL cs_byte%0d got %h exp %h", i, tx_b[t0+i], exp[i]);
                end
            end
        end
        repeat (4) step();
        r0 = req_c.size();
        e0 = err_cnt;
        tick();
        push(8'h03);
        push(8'h00);
        fr_x = 8'h00;
        repeat (10) step();
        checks++;
        if (err_cnt !== e0 + 1 || req_c.size() !== r0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cs_bad err %0d req %0d busy %b exp %0d %0d 0",
                     err_cnt, req_c.size(), busy, e0 + 1, r0);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic ok;
        int c;
        int r0;
        int t0;
        int q0;
        logic [7:0] exp [5] = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h04};
        r0 = req_c.size();
        q0 = re_cnt;
        tick();
        c = cyc;
        push(8'h87); push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        end_frame();
        push(8'h09);
        end_frame();
        wait_req(ok);
        checks++;
        if (ok !== 1'b1 || req_c[r0] !== c + 5 + CS || re_cnt - q0 !== 5 + CS) begin
            errors++;
            $display("FAIL b2b_first got %b at %0d reads %0d exp 1 at %0d reads %0d",
                     ok, req_c[r0], re_cnt - q0, c + 5 + CS, 5 + CS);
        end
        checks++;
        if ({we_reg, addr, wdata} !== {1'b1, 7'h07, 32'h44332211}) begin
            errors++;
            $display("FAIL b2b_wr got %b %h %h exp 1 07 44332211",
                     we_reg, addr, wdata);
        end
        do_ack(32'h0);
        wait_req(ok);
        checks++;
        if (ok !== 1'b1 || req_c[r0+1] - ack_cyc !== 2 + CS) begin
            errors++;
            $display("FAIL b2b_second got %b delta %0d exp 1 delta %0d",
                     ok, req_c[r0+1] - ack_cyc, 2 + CS);
        end
        checks++;
        if ({we_reg, addr} !== {1'b0, 7'h09}) begin
            errors++;
            $display("FAIL b2b_rd got %b %h exp 0 09", we_reg, addr);
        end
        t0 = tx_b.size();
        do_ack(32'h01020304);
        wait_tx(t0 + DB + CS, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_tx got %0d exp %0d", tx_b.size(), t0 + DB + CS);
        end
        if (ok) begin
            for (int i = 0; i < DB + CS; i++) begin
                checks++;
                if (tx_b[t0+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL b2b_byte%0d got %h exp %h", i, tx_b[t0+i], exp[i]);
                end
            end
        end
        repeat (4) step();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_stall();
        test_timeout();
        test_reset_mid_req();
`ifdef UART_CMD_DEFRAMER_CHECKSUM_EN
        test_checksum();
`endif
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
